p_mul_iter: RTL and testbench

P_MUL_ITER -- requirements
Module: p_mul_iter

---
 rtl/p_mul_iter.sv | 202 ++++++++++++++++++++
 tb/tb_p_mul_iter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_mul_iter.sv
// p_mul_iter: iterative packed multiplier, STEP multiplier bits per cycle.
// Each lane of width w (chosen by one-hot pw) forms a 2w-bit product. The
// result is the concatenated low halves or the concatenated high halves.
// Optional feature macro: P_MUL_ITER_CLMUL_EN builds the carry-less datapath.
module p_mul_iter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     valid,
  output logic                     ready,
  input  logic                     mul_l,
  input  logic                     mul_h,
  input  logic                     clmul,
  input  logic [$clog2(XLEN)-1:0]  pw,
  input  logic [XLEN-1:0]          crs1,
  input  logic [XLEN-1:0]          crs2,
  output logic [XLEN-1:0]          result
);

  localparam int unsigned LOGX  = $clog2(XLEN);
  localparam int unsigned NSTEP = XLEN / STEP;
  localparam int unsigned CW    = $clog2(NSTEP);
  localparam int unsigned AW    = 2 * XLEN;
  localparam int unsigned SHW   = LOGX + 1;
  localparam logic [CW-1:0] LAST = CW'(NSTEP - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     acc_q, acc_d, acc_nxt;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d;
  logic [LOGX-1:0]   pw_q, pw_d;
  logic              mul_l_q, mul_l_d, mul_h_q, mul_h_d;
  logic              ready_d;
  logic [XLEN-1:0]   result_d;
  logic [XLEN-1:0]   lo_sel, hi_sel;

  // Internally the accumulator keeps each lane product contiguous:
  // lane j of width w owns bits [2*j*w +: 2*w].
  logic [AW-1:0]     term   [LOGX][STEP];
  logic [XLEN-1:0]   lo_all [LOGX];
  logic [XLEN-1:0]   hi_all [LOGX];

`ifdef P_MUL_ITER_CLMUL_EN
  logic              clmul_q, clmul_d;
`else
  logic              unused_clmul;
  assign unused_clmul = clmul;
`endif

  for (genvar p = 0; p < LOGX; p++) begin : g_w
    localparam int unsigned W = XLEN >> p;
    localparam logic [LOGX-1:0] BMASK = ~LOGX'(W - 1);
    localparam logic [AW-1:0]   LMASK = {{(AW - W){1'b0}}, {W{1'b1}}};

    for (genvar s = 0; s < STEP; s++) begin : g_s
      logic [LOGX-1:0] idx;
      logic [LOGX-1:0] base;
      logic [SHW-1:0]  sh;
      assign idx  = LOGX'(32'(cnt_q) * STEP + s);
      assign base = idx & BMASK;
      // lane operand lands at field base 2*base, shifted by idx-base
      assign sh   = SHW'(idx) + SHW'(base);
      assign term[p][s] = (pw_q[p] && b_q[idx])
                        ? ((AW'(a_q >> base) & LMASK) << sh) : '0;
    end

    logic [XLEN-1:0] lo_w, hi_w;
    // Unpack lane product fields into low-half and high-half words
    always_comb begin
      lo_w = '0;
      hi_w = '0;
      for (int j = 0; j < int'(XLEN / W); j++) begin
        lo_w[j*W +: W] = acc_nxt[2*j*W +: W];
        hi_w[j*W +: W] = acc_nxt[2*j*W + W +: W];
      end
    end
    assign lo_all[p] = lo_w;
    assign hi_all[p] = hi_w;
  end

  // One step of partial-product accumulation; products never overflow
  // their 2w field so a full-width add cannot carry across lanes
  always_comb begin
    acc_nxt = acc_q;
    for (int p = 0; p < int'(LOGX); p++) begin
      for (int s = 0; s < int'(STEP); s++) begin
`ifdef P_MUL_ITER_CLMUL_EN
        if (clmul_q) acc_nxt = acc_nxt ^ term[p][s];
        else         acc_nxt = acc_nxt + term[p][s];
`else
        acc_nxt = acc_nxt + term[p][s];
`endif
      end
    end
  end

  // Select the half-words matching the captured lane width
  always_comb begin
    lo_sel = '0;
    hi_sel = '0;
    for (int p = 0; p < int'(LOGX); p++) begin
      if (pw_q[p]) begin
        lo_sel = lo_sel | lo_all[p];
        hi_sel = hi_sel | hi_all[p];
      end
    end
  end

  // Next-state, capture and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    pw_d     = pw_q;
    mul_l_d  = mul_l_q;
    mul_h_d  = mul_h_q;
`ifdef P_MUL_ITER_CLMUL_EN
    clmul_d  = clmul_q;
`endif
    ready_d  = 1'b0;
    result_d = '0;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          a_d     = crs1;
          b_d     = crs2;
          pw_d    = pw;
          mul_l_d = mul_l;
          mul_h_d = mul_h;
`ifdef P_MUL_ITER_CLMUL_EN
          clmul_d = clmul;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!valid) begin
          // requester withdrew: abort and discard
          state_d = IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          acc_d = acc_nxt;
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            if ($onehot(pw_q)) begin
              if (mul_l_q)      result_d = lo_sel;
              else if (mul_h_q) result_d = hi_sel;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      pw_q    <= '0;
      mul_l_q <= 1'b0;
      mul_h_q <= 1'b0;
`ifdef P_MUL_ITER_CLMUL_EN
      clmul_q <= 1'b0;
`endif
      ready   <= 1'b0;
      result  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      pw_q    <= pw_d;
      mul_l_q <= mul_l_d;
      mul_h_q <= mul_h_d;
`ifdef P_MUL_ITER_CLMUL_EN
      clmul_q <= clmul_d;
`endif
      ready   <= ready_d;
      result  <= result_d;
    end
  end

endmodule

// File: tb/tb_p_mul_iter.sv
// Bench for p_mul_iter: directed vectors on XLEN=32/STEP=4 and randomized
// requests on both XLEN=32/STEP=4 and XLEN=64/STEP=8 against a lane model.
module tb_p_mul_iter;

`ifdef P_MUL_ITER_CLMUL_EN
  localparam bit CL_EN = 1'b1;
`else
  localparam bit CL_EN = 1'b0;
`endif

  logic clock, reset;
  int   checks, errors;

  logic        v32, r32, l32, h32, c32;
  logic [4:0]  pw32;
  logic [31:0] a32, b32, res32;

  logic        v64, r64, l64, h64, c64;
  logic [5:0]  pw64;
  logic [63:0] a64, b64, res64;

  p_mul_iter #(.XLEN(32), .STEP(4)) u32 (
    .clock(clock), .reset(reset), .valid(v32), .ready(r32),
    .mul_l(l32), .mul_h(h32), .clmul(c32), .pw(pw32),
    .crs1(a32), .crs2(b32), .result(res32));

  p_mul_iter #(.XLEN(64), .STEP(8)) u64 (
    .clock(clock), .reset(reset), .valid(v64), .ready(r64),
    .mul_l(l64), .mul_h(h64), .clmul(c64), .pw(pw64),
    .crs1(a64), .crs2(b64), .result(res64));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Per-lane reference: split operands into lanes, multiply each lane pair
  function automatic logic [63:0] ref_mul(input int xlen, input logic [5:0] pw,
                                          input bit l, input bit h, input bit cl,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  lo, hi, m, x, y, xm;
    logic [127:0] pr;
    int w, lw;
    lo = '0; hi = '0;
    lw = $clog2(xlen);
    xm = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    if ($countones(pw) != 1) return '0;
    w = xlen;
    for (int p = 0; p < lw; p++) if (pw[p]) w = xlen >> p;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int j = 0; j < xlen / w; j++) begin
      x = (a >> (j * w)) & m;
      y = (b >> (j * w)) & m;
      if (cl) begin
        pr = '0;
        for (int t = 0; t < w; t++) if (y[t]) pr = pr ^ (128'(x) << t);
      end else begin
        pr = 128'(x) * 128'(y);
      end
      lo = lo | ((pr[63:0] & m) << (j * w));
      hi = hi | ((64'(pr >> w) & m) << (j * w));
    end
    if (l) return lo & xm;
    if (h) return hi & xm;
    return '0;
  endfunction

  task automatic run32(input logic [31:0] a, input logic [31:0] b, input logic [4:0] pw,
                       input bit l, input bit h, input bit c, input bit keep, input bit scr,
                       output logic [31:0] res, output int lat);
    a32 = a; b32 = b; pw32 = pw; l32 = l; h32 = h; c32 = c; v32 = 1'b1;
    lat = 0; res = '0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      lat++;
      if (scr && lat == 1) begin
        a32 = $urandom; b32 = $urandom; pw32 = 5'($urandom);
        l32 = 1'($urandom); h32 = 1'($urandom); c32 = 1'($urandom);
      end
      if (r32) begin
        res = res32;
        break;
      end
      checks++;
      if (res32 !== 32'h0) begin
        errors++;
        $display("FAIL idle_result32 got %h exp 00000000", res32);
      end
    end
    if (!keep) v32 = 1'b0;
  endtask

  task automatic run64(input logic [63:0] a, input logic [63:0] b, input logic [5:0] pw,
                       input bit l, input bit h, input bit c,
                       output logic [63:0] res, output int lat);
    a64 = a; b64 = b; pw64 = pw; l64 = l; h64 = h; c64 = c; v64 = 1'b1;
    lat = 0; res = '0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      lat++;
      if (r64) begin
        res = res64;
        break;
      end
    end
    v64 = 1'b0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp,
                         input int lat);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s result got %h exp %h", name, got, exp);
    end
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL %s latency got %0d exp 9", name, lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    v32 = 0; l32 = 0; h32 = 0; c32 = 0; pw32 = '0; a32 = '0; b32 = '0;
    v64 = 0; l64 = 0; h64 = 0; c64 = 0; pw64 = '0; a64 = '0; b64 = '0;
    #2;
    checks++;
    if (r32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL reset32 got ready=%b result=%h exp ready=0 result=0", r32, res32);
    end
    checks++;
    if (r64 !== 1'b0 || res64 !== 64'h0) begin
      errors++;
      $display("FAIL reset64 got ready=%b result=%h exp ready=0 result=0", r64, res64);
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int lat;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 1, 0, 0, 0, 0, res, lat);
    check32("ones_lo", res, 32'h0000_0001, lat);
    checks++;
    @(posedge clock); #1;
    if (r32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL ready_pulse got ready=%b result=%h exp ready=0 result=0", r32, res32);
    end
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 0, 1, 0, 0, 0, res, lat);
    check32("ones_hi", res, 32'hFFFF_FFFE, lat);
    run32(32'h1010_1010, 32'h1010_1010, 5'b00100, 1, 0, 0, 0, 0, res, lat);
    check32("byte_lo", res, 32'h0000_0000, lat);
    run32(32'h1010_1010, 32'h1010_1010, 5'b00100, 0, 1, 0, 0, 0, res, lat);
    check32("byte_hi", res, 32'h0101_0101, lat);
    run32(32'h0000_0003, 32'h0000_0003, 5'b00001, 1, 0, 1, 0, 0, res, lat);
    check32("clmul3", res, CL_EN ? 32'h0000_0005 : 32'h0000_0009, lat);
    run32(32'hDEAD_BEEF, 32'h1234_5678, 5'b00011, 1, 0, 0, 0, 0, res, lat);
    check32("pw_not_onehot", res, 32'h0, lat);
    run32(32'hDEAD_BEEF, 32'h1234_5678, 5'b10000, 0, 0, 0, 0, 0, res, lat);
    check32("no_half_sel", res, 32'h0, lat);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b10000, 0, 1, 0, 0, 0, res, lat);
    check32("pair_hi", res, 32'hAAAA_AAAA, lat);
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    int lat;
    run32(32'h0001_0002, 32'h0003_0004, 5'b00010, 1, 0, 0, 1, 0, res, lat);
    check32("b2b_first", res, 32'h0003_0008, lat);
    run32(32'h8000_0001, 32'h0000_0002, 5'b00001, 0, 1, 0, 0, 0, res, lat);
    check32("b2b_second", res, 32'h0000_0001, lat);
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat, seen;
    a32 = 32'h1234_5678; b32 = 32'h9ABC_DEF0; pw32 = 5'b00001;
    l32 = 1; h32 = 0; c32 = 0; v32 = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    v32 = 1'b0;
    seen = 0;
    repeat (15) begin @(posedge clock); #1; if (r32) seen++; end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL abort_ready got %0d pulses exp 0", seen);
    end
    run32(32'h0000_00FF, 32'h0000_0101, 5'b00001, 1, 0, 0, 0, 0, res, lat);
    check32("after_abort", res, 32'h0000_FFFF, lat);
  endtask

  task automatic test_reset_busy();
    logic [31:0] res;
    int lat;
    a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF; pw32 = 5'b00001;
    l32 = 1; h32 = 0; c32 = 0; v32 = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    reset = 1'b1; v32 = 1'b0;
    #1;
    checks++;
    if (r32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got ready=%b result=%h exp ready=0 result=0", r32, res32);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b00001, 0, 1, 0, 1, 0, res, lat);
    check32("pre_reset_op", res, 32'hFFFF_FFFE, lat);
    reset = 1'b1; v32 = 1'b0;
    #1;
    checks++;
    if (r32 !== 1'b0 || res32 !== 32'h0) begin
      errors++;
      $display("FAIL reset_ready got ready=%b result=%h exp ready=0 result=0", r32, res32);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    run32(32'h0000_1234, 32'h0000_0010, 5'b00001, 1, 0, 0, 0, 0, res, lat);
    check32("post_reset", res, 32'h0001_2340, lat);
  endtask

  task automatic test_random32();
    logic [31:0] a, b, res, exp;
    logic [4:0]  pw;
    bit l, h, c, scr;
    int lat;
    for (int n = 0; n < 400; n++) begin
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 15) == 0) pw = 5'($urandom);
      else pw = 5'(1) << $urandom_range(0, 4);
      l = 1'($urandom); h = 1'($urandom); c = 1'($urandom);
      scr = 1'($urandom);
      exp = 32'(ref_mul(32, {1'b0, pw}, l, h, c & CL_EN, 64'(a), 64'(b)));
      run32(a, b, pw, l, h, c, 0, scr, res, lat);
      check32("rand32", res, exp, lat);
    end
  endtask

  task automatic test_random64();
    logic [63:0] a, b, res, exp;
    logic [5:0]  pw;
    bit l, h, c;
    int lat;
    for (int n = 0; n < 2000; n++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) pw = 6'($urandom);
      else pw = 6'(1) << $urandom_range(0, 5);
      l = 1'($urandom); h = 1'($urandom); c = 1'($urandom);
      exp = ref_mul(64, pw, l, h, c & CL_EN, a, b);
      run64(a, b, pw, l, h, c, res, lat);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL rand64 pw=%b got %h exp %h", pw, res, exp);
      end
      checks++;
      if (lat !== 9) begin
        errors++;
        $display("FAIL rand64_latency got %0d exp 9", lat);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_reset_busy();
    test_random32();
    test_random64();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
